axi_4_mem_arbiter: RTL and testbench

Shares the single user-side port of the AXI4 master between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write). It arbitrates read transactions round-robin and passes LSU writes through with burst and response tracking. It also enforces LSU read/write ordering. It sits between the core's fetch/LSU stages and the AXI4 master in `npc/vsrc/axi_4/`.

---
 rtl/axi_4_mem_arbiter_pkg.sv | 22 ++
 rtl/axi_4_mem_arbiter_beat_cnt.sv | 32 +++
 rtl/axi_4_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_axi_4_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_4_mem_arbiter_pkg.sv
// Shared types and constants for the AXI4 memory arbiter slice.
package axi_4_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_IFU  = 2'd1,
    R_LSU  = 2'd2
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/axi_4_mem_arbiter_beat_cnt.sv
// Burst beat tracker: latches the burst length and counts accepted beats.
module axi_4_beat_cnt
  import axi_4_mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  input  logic             inc,
  output logic             last
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;

  // A beat accepted in the same cycle as the load is counted, so the
  // burst still completes after exactly len+1 beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      len_q <= '0;
    end else if (load) begin
      len_q <= len;
      cnt   <= inc ? CNT_W'(1) : '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == len_q);

endmodule

// File: rtl/axi_4_mem_arbiter.sv
// Shares the AXI4 master user port between IFU reads and LSU reads/writes,
// with round-robin read arbitration and LSU read/write ordering.
module axi_4_mem_arbiter
  import axi_4_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_r_req,
  input  logic [ADDR_W-1:0] ifu_r_addr,
  input  logic [2:0]        ifu_r_size,
  input  logic [1:0]        ifu_r_burst,
  input  logic [7:0]        ifu_r_len,
  output logic              ifu_r_valid,

  input  logic              lsu_r_req,
  input  logic [ADDR_W-1:0] lsu_r_addr,
  input  logic [2:0]        lsu_r_size,
  input  logic [1:0]        lsu_r_burst,
  input  logic [7:0]        lsu_r_len,
  output logic              lsu_r_valid,

  output logic [DATA_W-1:0] r_data,

  input  logic              lsu_w_valid,
  input  logic [ADDR_W-1:0] lsu_w_addr,
  input  logic [2:0]        lsu_w_size,
  input  logic [1:0]        lsu_w_burst,
  input  logic [7:0]        lsu_w_len,
  input  logic [STRB_W-1:0] lsu_w_strb,
  input  logic [DATA_W-1:0] lsu_w_data,
  output logic              lsu_w_ready,
  output logic              lsu_w_done,

  output logic              m_r_ready,
  output logic [ADDR_W-1:0] m_r_addr,
  output logic [2:0]        m_r_size,
  output logic [1:0]        m_r_burst,
  output logic [7:0]        m_r_len,
  input  logic              m_r_valid,
  input  logic [DATA_W-1:0] m_r_data,

  output logic              m_w_valid,
  output logic [ADDR_W-1:0] m_w_addr,
  output logic [2:0]        m_w_size,
  output logic [1:0]        m_w_burst,
  output logic [7:0]        m_w_len,
  output logic [STRB_W-1:0] m_w_strb,
  output logic [DATA_W-1:0] m_w_data,
  input  logic              m_w_ready,
  input  logic              m_b_done
);

  rstate_t rstate, rnext;
  wstate_t wstate, wnext;
  logic    last_lsu;

  logic       ifu_elig, lsu_elig;
  logic       grant_lsu, r_load, r_inc, r_last;
  logic [7:0] r_len_sel;
  logic       w_go, w_start, w_inc, w_last;

  assign ifu_elig = ifu_r_req;
  assign lsu_elig = lsu_r_req && (wstate == W_IDLE) && !lsu_w_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate   <= R_IDLE;
      wstate   <= W_IDLE;
      last_lsu <= 1'b0;
    end else begin
      rstate <= rnext;
      wstate <= wnext;
      if (r_load) last_lsu <= grant_lsu;
    end
  end

  always_comb begin
    rnext     = rstate;
    grant_lsu = 1'b0;
    r_load    = 1'b0;
    unique case (rstate)
      R_IDLE: begin
        if (ifu_elig || lsu_elig) begin
          r_load    = 1'b1;
          grant_lsu = lsu_elig && (!ifu_elig || !last_lsu);
          rnext     = grant_lsu ? R_LSU : R_IFU;
        end
      end
      R_IFU, R_LSU: begin
        if (m_r_valid && r_last) rnext = R_IDLE;
      end
      default: rnext = R_IDLE;
    endcase
  end

  assign r_len_sel = grant_lsu ? lsu_r_len : ifu_r_len;
  assign r_inc     = (rstate != R_IDLE) && m_r_valid;

  axi_4_beat_cnt u_r_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (r_load),
    .len  (r_len_sel),
    .inc  (r_inc),
    .last (r_last)
  );

  always_comb begin
    wnext   = wstate;
    w_go    = 1'b0;
    w_start = 1'b0;
    unique case (wstate)
      W_IDLE: begin
        w_go = lsu_w_valid && (rstate != R_LSU);
        if (w_go) begin
          w_start = 1'b1;
          wnext   = (lsu_w_len == 8'd0 && m_w_ready) ? W_RESP : W_DATA;
        end
      end
      W_DATA: begin
        w_go = lsu_w_valid;
        if (m_w_ready && w_last) wnext = W_RESP;
      end
      W_RESP: begin
        if (m_b_done) wnext = W_IDLE;
      end
      default: wnext = W_IDLE;
    endcase
  end

  assign w_inc = m_w_ready && (w_start || wstate == W_DATA);

  axi_4_beat_cnt u_w_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (w_start),
    .len  (lsu_w_len),
    .inc  (w_inc),
    .last (w_last)
  );

  always_comb begin
    m_r_ready = 1'b0;
    unique case (rstate)
      R_IFU:   m_r_ready = ifu_r_req;
      R_LSU:   m_r_ready = lsu_r_req;
      default: m_r_ready = 1'b0;
    endcase
  end

  assign m_r_addr  = (rstate == R_LSU) ? lsu_r_addr  : ifu_r_addr;
  assign m_r_size  = (rstate == R_LSU) ? lsu_r_size  : ifu_r_size;
  assign m_r_burst = (rstate == R_LSU) ? lsu_r_burst : ifu_r_burst;
  assign m_r_len   = (rstate == R_LSU) ? lsu_r_len   : ifu_r_len;

  assign ifu_r_valid = (rstate == R_IFU) && m_r_valid;
  assign lsu_r_valid = (rstate == R_LSU) && m_r_valid;
  assign r_data      = m_r_data;

  // Write-side outputs follow live inputs in W_IDLE, so they are masked
  // while reset is held.
  assign m_w_valid   = rst && w_go;
  assign lsu_w_ready = rst && m_w_ready && (wstate != W_RESP);
  assign lsu_w_done  = rst && m_b_done && (wstate == W_RESP);

  assign m_w_addr  = lsu_w_addr;
  assign m_w_size  = lsu_w_size;
  assign m_w_burst = lsu_w_burst;
  assign m_w_len   = lsu_w_len;
  assign m_w_strb  = lsu_w_strb;
  assign m_w_data  = lsu_w_data;

endmodule

// File: tb/tb_axi_4_mem_arbiter.sv
// Directed self-checking bench for axi_4_mem_arbiter.
module tb_axi_4_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = 8;

  logic              clk, rst;
  logic              ifu_r_req, lsu_r_req, lsu_w_valid;
  logic [ADDR_W-1:0] ifu_r_addr, lsu_r_addr, lsu_w_addr;
  logic [2:0]        ifu_r_size, lsu_r_size, lsu_w_size;
  logic [1:0]        ifu_r_burst, lsu_r_burst, lsu_w_burst;
  logic [7:0]        ifu_r_len, lsu_r_len, lsu_w_len;
  logic [STRB_W-1:0] lsu_w_strb;
  logic [DATA_W-1:0] lsu_w_data;
  logic              ifu_r_valid, lsu_r_valid, lsu_w_ready, lsu_w_done;
  logic [DATA_W-1:0] r_data;
  logic              m_r_ready, m_r_valid;
  logic [ADDR_W-1:0] m_r_addr;
  logic [2:0]        m_r_size;
  logic [1:0]        m_r_burst;
  logic [7:0]        m_r_len;
  logic [DATA_W-1:0] m_r_data;
  logic              m_w_valid, m_w_ready, m_b_done;
  logic [ADDR_W-1:0] m_w_addr;
  logic [2:0]        m_w_size;
  logic [1:0]        m_w_burst;
  logic [7:0]        m_w_len;
  logic [STRB_W-1:0] m_w_strb;
  logic [DATA_W-1:0] m_w_data;

  int checks = 0;
  int errors = 0;

  axi_4_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_r_req(ifu_r_req), .ifu_r_addr(ifu_r_addr), .ifu_r_size(ifu_r_size),
    .ifu_r_burst(ifu_r_burst), .ifu_r_len(ifu_r_len), .ifu_r_valid(ifu_r_valid),
    .lsu_r_req(lsu_r_req), .lsu_r_addr(lsu_r_addr), .lsu_r_size(lsu_r_size),
    .lsu_r_burst(lsu_r_burst), .lsu_r_len(lsu_r_len), .lsu_r_valid(lsu_r_valid),
    .r_data(r_data),
    .lsu_w_valid(lsu_w_valid), .lsu_w_addr(lsu_w_addr), .lsu_w_size(lsu_w_size),
    .lsu_w_burst(lsu_w_burst), .lsu_w_len(lsu_w_len), .lsu_w_strb(lsu_w_strb),
    .lsu_w_data(lsu_w_data), .lsu_w_ready(lsu_w_ready), .lsu_w_done(lsu_w_done),
    .m_r_ready(m_r_ready), .m_r_addr(m_r_addr), .m_r_size(m_r_size),
    .m_r_burst(m_r_burst), .m_r_len(m_r_len), .m_r_valid(m_r_valid), .m_r_data(m_r_data),
    .m_w_valid(m_w_valid), .m_w_addr(m_w_addr), .m_w_size(m_w_size),
    .m_w_burst(m_w_burst), .m_w_len(m_w_len), .m_w_strb(m_w_strb),
    .m_w_data(m_w_data), .m_w_ready(m_w_ready), .m_b_done(m_b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks land 2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b0;
    ifu_r_req = 0; ifu_r_addr = '0; ifu_r_size = 3'd3; ifu_r_burst = 2'd2; ifu_r_len = '0;
    lsu_r_req = 0; lsu_r_addr = '0; lsu_r_size = 3'd2; lsu_r_burst = 2'd1; lsu_r_len = '0;
    lsu_w_valid = 1; lsu_w_addr = '0; lsu_w_size = 3'd3; lsu_w_burst = 2'd1; lsu_w_len = '0;
    lsu_w_strb = '1; lsu_w_data = '0;
    m_r_valid = 0; m_r_data = '0; m_w_ready = 1; m_b_done = 1;
    settle();
    chk("rst_m_r_ready", m_r_ready, 0);
    chk("rst_m_w_valid", m_w_valid, 0);
    chk("rst_lsu_w_ready", lsu_w_ready, 0);
    chk("rst_lsu_w_done", lsu_w_done, 0);
    chk("rst_ifu_r_valid", ifu_r_valid, 0);
    chk("rst_lsu_r_valid", lsu_r_valid, 0);
    tick();
    lsu_w_valid = 0; m_w_ready = 0; m_b_done = 0;
    tick();
    rst = 1'b1;

    // IFU single read
    ifu_r_req = 1; ifu_r_len = 8'd0; ifu_r_addr = 32'h8000_0000;
    settle();
    chk("t1_idle_ready", m_r_ready, 0);
    tick();
    m_r_valid = 1; m_r_data = 64'h1122_3344_5566_7788;
    settle();
    chk("t1_ready", m_r_ready, 1);
    chk("t1_addr", m_r_addr, 64'h8000_0000);
    chk("t1_ifu_valid", ifu_r_valid, 1);
    chk("t1_lsu_valid", lsu_r_valid, 0);
    chk("t1_data", r_data, 64'h1122_3344_5566_7788);
    tick();
    m_r_valid = 0;
    settle();
    chk("t1_bubble", m_r_ready, 0);
    chk("t1_no_valid", ifu_r_valid, 0);
    ifu_r_req = 0;

    // Tie after IFU-only history: LSU wins first
    tick();
    ifu_r_req = 1; ifu_r_len = 8'd3; ifu_r_addr = 32'h2000;
    lsu_r_req = 1; lsu_r_len = 8'd3; lsu_r_addr = 32'h1000;
    tick();
    settle();
    chk("t2_lsu_ready", m_r_ready, 1);
    chk("t2_lsu_addr", m_r_addr, 64'h1000);
    chk("t2_lsu_burst", m_r_burst, 1);
    chk("t2_lsu_len", m_r_len, 3);
    for (int i = 0; i < 4; i++) begin
      m_r_valid = 1; m_r_data = 64'(i + 16);
      settle();
      chk("t2_lsu_beat", lsu_r_valid, 1);
      chk("t2_ifu_quiet", ifu_r_valid, 0);
      chk("t2_lsu_data", r_data, 64'(i + 16));
      tick();
    end
    m_r_valid = 0; lsu_r_req = 0;
    settle();
    chk("t2_bubble", m_r_ready, 0);
    tick();
    settle();
    chk("t2_ifu_addr", m_r_addr, 64'h2000);
    chk("t2_ifu_burst", m_r_burst, 2);
    for (int i = 0; i < 4; i++) begin
      m_r_valid = 1;
      settle();
      chk("t2_ifu_beat", ifu_r_valid, 1);
      chk("t2_lsu_quiet", lsu_r_valid, 0);
      tick();
    end
    m_r_valid = 0; ifu_r_req = 0;
    settle();
    chk("t2_ifu_end", m_r_ready, 0);

    // LSU burst write, len 3
    tick();
    lsu_w_valid = 1; lsu_w_len = 8'd3; lsu_w_addr = 32'h3000; lsu_w_data = 64'd0; m_w_ready = 1;
    settle();
    chk("t3_w_valid0", m_w_valid, 1);
    chk("t3_w_addr", m_w_addr, 64'h3000);
    chk("t3_w_ready0", lsu_w_ready, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      lsu_w_data = 64'(i);
      settle();
      chk("t3_w_valid", m_w_valid, 1);
      chk("t3_w_ready", lsu_w_ready, 1);
      chk("t3_w_data", m_w_data, 64'(i));
    end
    tick();
    settle();
    chk("t3_resp_no_valid", m_w_valid, 0);
    chk("t3_resp_no_ready", lsu_w_ready, 0);
    chk("t3_resp_no_done", lsu_w_done, 0);
    lsu_w_valid = 0; m_w_ready = 0;
    tick();
    m_b_done = 1;
    settle();
    chk("t3_done", lsu_w_done, 1);
    tick();
    m_b_done = 0;
    settle();
    chk("t3_done_pulse", lsu_w_done, 0);

    // Ordering: LSU read waits for write response, IFU proceeds
    lsu_w_valid = 1; lsu_w_len = 8'd1; m_w_ready = 1;
    settle();
    chk("t4_w_beat0", lsu_w_ready, 1);
    tick();
    settle();
    chk("t4_w_beat1", lsu_w_ready, 1);
    tick();
    lsu_w_valid = 0; m_w_ready = 0;
    lsu_r_req = 1; lsu_r_len = 8'd0; lsu_r_addr = 32'h4000;
    ifu_r_req = 1; ifu_r_len = 8'd0; ifu_r_addr = 32'h5000;
    settle();
    chk("t4_idle", m_r_ready, 0);
    tick();
    m_r_valid = 1; m_b_done = 1;
    settle();
    chk("t4_ifu_granted", m_r_addr, 64'h5000);
    chk("t4_ifu_valid", ifu_r_valid, 1);
    chk("t4_w_done", lsu_w_done, 1);
    tick();
    m_r_valid = 0; m_b_done = 0; ifu_r_req = 0;
    settle();
    chk("t4_lsu_not_yet", m_r_ready, 0);
    tick();
    lsu_w_valid = 1; lsu_w_len = 8'd0; m_r_valid = 1;
    settle();
    chk("t4_lsu_ready", m_r_ready, 1);
    chk("t4_lsu_addr", m_r_addr, 64'h4000);
    chk("t4_lsu_valid", lsu_r_valid, 1);
    chk("t4_w_held_off", m_w_valid, 0);
    lsu_w_valid = 0;
    tick();
    m_r_valid = 0; lsu_r_req = 0;

    // Same-cycle LSU read and write: write first
    tick();
    lsu_r_req = 1; lsu_r_len = 8'd0; lsu_r_addr = 32'h6000;
    lsu_w_valid = 1; lsu_w_len = 8'd0; lsu_w_addr = 32'h7000; m_w_ready = 1;
    settle();
    chk("t5_w_first", m_w_valid, 1);
    chk("t5_w_ready", lsu_w_ready, 1);
    tick();
    lsu_w_valid = 0; m_w_ready = 0;
    settle();
    chk("t5_no_read1", m_r_ready, 0);
    chk("t5_resp_valid", m_w_valid, 0);
    tick();
    m_b_done = 1;
    settle();
    chk("t5_no_read2", m_r_ready, 0);
    chk("t5_done", lsu_w_done, 1);
    tick();
    m_b_done = 0;
    settle();
    chk("t5_no_read3", m_r_ready, 0);
    tick();
    m_r_valid = 1;
    settle();
    chk("t5_read_ready", m_r_ready, 1);
    chk("t5_read_addr", m_r_addr, 64'h6000);
    chk("t5_read_valid", lsu_r_valid, 1);
    tick();
    m_r_valid = 0;

    // Tie after LSU grant: IFU wins, then LSU
    ifu_r_req = 1; ifu_r_addr = 32'h9000; ifu_r_len = 8'd0;
    lsu_r_addr = 32'hA000;
    tick();
    m_r_valid = 1;
    settle();
    chk("t5b_ifu_wins", m_r_addr, 64'h9000);
    chk("t5b_ifu_valid", ifu_r_valid, 1);
    tick();
    m_r_valid = 0; ifu_r_req = 0;
    tick();
    m_r_valid = 1;
    settle();
    chk("t5b_lsu_next", m_r_addr, 64'hA000);
    chk("t5b_lsu_valid", lsu_r_valid, 1);
    tick();
    m_r_valid = 0; lsu_r_req = 0;

    // Reset during beat 2 of an IFU len-7 read
    ifu_r_req = 1; ifu_r_len = 8'd7; ifu_r_addr = 32'h8000_0100;
    tick();
    m_r_valid = 1;
    settle();
    chk("t6_beat1", ifu_r_valid, 1);
    tick();
    rst = 0; lsu_w_valid = 1; m_w_ready = 1; m_b_done = 1;
    settle();
    chk("t6_rst_ready", m_r_ready, 0);
    chk("t6_rst_ifu_valid", ifu_r_valid, 0);
    chk("t6_rst_lsu_valid", lsu_r_valid, 0);
    chk("t6_rst_w_valid", m_w_valid, 0);
    chk("t6_rst_w_ready", lsu_w_ready, 0);
    chk("t6_rst_w_done", lsu_w_done, 0);
    tick();
    rst = 1; m_r_valid = 0; lsu_w_valid = 0; m_w_ready = 0; m_b_done = 0; ifu_r_len = 8'd1;
    settle();
    chk("t6_after_idle", m_r_ready, 0);
    tick();
    m_r_valid = 1;
    settle();
    chk("t6_new_ready", m_r_ready, 1);
    chk("t6_new_beat0", ifu_r_valid, 1);
    tick();
    settle();
    chk("t6_new_beat1", m_r_ready, 1);
    tick();
    m_r_valid = 0; ifu_r_req = 0;
    settle();
    chk("t6_new_end", m_r_ready, 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
